// File: rtl/game_pkg.sv
// Shared definitions for the game FSM and its timing controller:
// state encodings and the BCD digit type.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE           = 2'b00,
    OPENING_SCREEN = 2'b01,
    GAME_RUNNING   = 2'b10,
    GAME_OVER      = 2'b11
  } game_state_t;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/sec_prescaler.sv
// Divides game_clk down to a one-cycle sec_tick every TICKS_PER_SEC cycles;
// clear restarts the period.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic game_clk,
  input  logic rst,
  input  logic clear,
  output logic sec_tick
);

  localparam int CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] presc_q, presc_d;

  assign sec_tick = !clear && (presc_q == LAST);

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (clear || sec_tick) presc_d = '0;
  end

  always_ff @(posedge game_clk or negedge rst) begin
    if (!rst) presc_q <= '0;
    else      presc_q <= presc_d;
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// MM:SS BCD countdown, GAME_OVER linger timeout and IDLE seconds counter,
// all sequenced from the game FSM state and a shared 1 s tick.
module game_timer_ctrl
  import game_pkg::*;
#(
  parameter int          TICKS_PER_SEC = 1000,
  parameter logic [15:0] START_TIME    = 16'h0130,
  parameter int          LINGER_SEC    = 3
) (
  input  logic       game_clk,
  input  logic       rst,
  input  logic [1:0] game_state_w,
  output logic [3:0] num0_w,
  output logic [3:0] num1_w,
  output logic [3:0] num2_w,
  output logic [3:0] num3_w,
  output logic       go_back_to_idle,
  output logic [3:0] game_over_seconds_w
);

  game_state_t cur_state, prev_state_q;
  bcd_t        num0_q, num0_d, num1_q, num1_d, num2_q, num2_d, num3_q, num3_d;
  logic [3:0]  linger_q, linger_d, gos_q, gos_d;
  logic        go_q, go_d;
  logic        entry, sec_tick;

  assign cur_state = game_state_t'(game_state_w);
  assign entry     = (cur_state != prev_state_q);

  sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_presc (
    .game_clk (game_clk),
    .rst      (rst),
    .clear    (entry || (cur_state == OPENING_SCREEN)),
    .sec_tick (sec_tick)
  );

  always_comb begin
    num0_d   = num0_q;
    num1_d   = num1_q;
    num2_d   = num2_q;
    num3_d   = num3_q;
    linger_d = linger_q;
    gos_d    = gos_q;
    go_d     = go_q;
    case (cur_state)
      OPENING_SCREEN: begin
        {num3_d, num2_d, num1_d, num0_d} = START_TIME;
        linger_d = '0;
        gos_d    = '0;
        go_d     = 1'b0;
      end
      GAME_RUNNING: begin
        // Count down with BCD borrow; 00:00 holds so the FSM can see it.
        if (sec_tick && ({num3_q, num2_q, num1_q, num0_q} != 16'h0000)) begin
          if (num0_q != 4'd0) num0_d = num0_q - 4'd1;
          else begin
            num0_d = 4'd9;
            if (num1_q != 4'd0) num1_d = num1_q - 4'd1;
            else begin
              num1_d = 4'd5;
              if (num2_q != 4'd0) num2_d = num2_q - 4'd1;
              else begin
                num2_d = 4'd9;
                num3_d = num3_q - 4'd1;
              end
            end
          end
        end
      end
      GAME_OVER: begin
        if (entry) begin
          linger_d = '0;
          go_d     = 1'b0;
        end else if (sec_tick && (linger_q != 4'd15)) begin
          linger_d = linger_q + 4'd1;
          if (linger_d == 4'(LINGER_SEC)) go_d = 1'b1;
        end
      end
      IDLE: begin
        if (entry) begin
          gos_d = '0;
          go_d  = 1'b0;
        end else if (sec_tick && (gos_q != 4'd15)) begin
          gos_d = gos_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge game_clk or negedge rst) begin
    if (!rst) begin
      prev_state_q                     <= OPENING_SCREEN;
      {num3_q, num2_q, num1_q, num0_q} <= START_TIME;
      linger_q                         <= '0;
      gos_q                            <= '0;
      go_q                             <= 1'b0;
    end else begin
      prev_state_q <= cur_state;
      num0_q       <= num0_d;
      num1_q       <= num1_d;
      num2_q       <= num2_d;
      num3_q       <= num3_d;
      linger_q     <= linger_d;
      gos_q        <= gos_d;
      go_q         <= go_d;
    end
  end

  assign num0_w              = num0_q;
  assign num1_w              = num1_q;
  assign num2_w              = num2_q;
  assign num3_w              = num3_q;
  assign go_back_to_idle     = go_q;
  assign game_over_seconds_w = gos_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl with TICKS_PER_SEC=4, START_TIME=01:30,
// LINGER_SEC=3; expected values are hand-derived from the tick timing.
module tb_game_timer_ctrl;

  logic       game_clk = 1'b0;
  logic       rst;
  logic [1:0] game_state_w;
  logic [3:0] num0_w, num1_w, num2_w, num3_w;
  logic       go_back_to_idle;
  logic [3:0] game_over_seconds_w;

  int check_count = 0;
  int pass_count  = 0;

  game_timer_ctrl #(
    .TICKS_PER_SEC (4),
    .START_TIME    (16'h0130),
    .LINGER_SEC    (3)
  ) dut (
    .game_clk            (game_clk),
    .rst                 (rst),
    .game_state_w        (game_state_w),
    .num0_w              (num0_w),
    .num1_w              (num1_w),
    .num2_w              (num2_w),
    .num3_w              (num3_w),
    .go_back_to_idle     (go_back_to_idle),
    .game_over_seconds_w (game_over_seconds_w)
  );

  always #5 game_clk = ~game_clk;

  task automatic applyStimulus(input logic r, input logic [1:0] s);
    rst          = r;
    game_state_w = s;
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic stepEdges(input int n);
    repeat (n) @(posedge game_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  function automatic logic [15:0] digits();
    return {num3_w, num2_w, num1_w, num0_w};
  endfunction

  initial begin
    applyStimulus(1'b0, 2'b01);
    #12;
    checkOutput("reset_digits", digits(), 16'h0130);
    checkOutput("reset_go", {15'd0, go_back_to_idle}, 16'd0);
    checkOutput("reset_gos", {12'd0, game_over_seconds_w}, 16'd0);
    stepEdges(1);
    applyStimulus(1'b1, 2'b01);
    stepEdges(3);
    checkOutput("opening_digits", digits(), 16'h0130);

    // First play session: 10 seconds then GAME_OVER.
    applyStimulus(1'b1, 2'b10);
    stepEdges(4);
    checkOutput("before_first_tick", digits(), 16'h0130);
    stepEdges(1);
    checkOutput("first_tick", digits(), 16'h0129);
    stepEdges(4 * 9);
    checkOutput("tick10", digits(), 16'h0120);

    applyStimulus(1'b1, 2'b11);
    stepEdges(12);
    checkOutput("linger_edge12_go", {15'd0, go_back_to_idle}, 16'd0);
    stepEdges(1);
    checkOutput("linger_edge13_go", {15'd0, go_back_to_idle}, 16'd1);
    checkOutput("gameover_frozen", digits(), 16'h0120);
    stepEdges(8);
    checkOutput("linger_hold_go", {15'd0, go_back_to_idle}, 16'd1);

    // IDLE seconds counter: value k is held on edges 4k+1 .. 4k+4.
    applyStimulus(1'b1, 2'b00);
    stepEdges(1);
    checkOutput("idle_entry_go", {15'd0, go_back_to_idle}, 16'd0);
    checkOutput("idle_entry_gos", {12'd0, game_over_seconds_w}, 16'd0);
    stepEdges(3);
    checkOutput("idle_gos0_end", {12'd0, game_over_seconds_w}, 16'd0);
    for (int k = 1; k <= 8; k++) begin
      stepEdges(1);
      checkOutput("idle_gos_first", {12'd0, game_over_seconds_w}, 16'(k));
      stepEdges(3);
      checkOutput("idle_gos_last", {12'd0, game_over_seconds_w}, 16'(k));
    end
    stepEdges(4 * 12);
    checkOutput("idle_gos_sat", {12'd0, game_over_seconds_w}, 16'd15);
    checkOutput("idle_frozen", digits(), 16'h0120);

    applyStimulus(1'b1, 2'b01);
    stepEdges(1);
    checkOutput("reload_digits", digits(), 16'h0130);
    checkOutput("reload_gos", {12'd0, game_over_seconds_w}, 16'd0);

    // Full countdown with minute borrow and hold at zero.
    applyStimulus(1'b1, 2'b10);
    stepEdges(5);
    checkOutput("run2_tick1", digits(), 16'h0129);
    stepEdges(4 * 29);
    checkOutput("tick30", digits(), 16'h0100);
    stepEdges(4);
    checkOutput("tick31_borrow", digits(), 16'h0059);
    stepEdges(4 * 58);
    checkOutput("tick89", digits(), 16'h0001);
    stepEdges(4);
    checkOutput("tick90_zero", digits(), 16'h0000);
    for (int t = 91; t <= 93; t++) begin
      stepEdges(4);
      checkOutput("hold_zero", digits(), 16'h0000);
    end

    applyStimulus(1'b1, 2'b01);
    stepEdges(1);
    checkOutput("reload_after_zero", digits(), 16'h0130);

    // Asynchronous reset in the middle of a run.
    applyStimulus(1'b1, 2'b10);
    stepEdges(5 + 4 * 12);
    checkOutput("tick13", digits(), 16'h0117);
    #3;
    applyStimulus(1'b0, 2'b10);
    #1;
    checkOutput("async_reset_digits", digits(), 16'h0130);
    checkOutput("async_reset_gos", {12'd0, game_over_seconds_w}, 16'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/game_timer_ctrl.md
# game_timer_ctrl

Timing controller that feeds the game-state FSM. It generates the 1 s tick from `game_clk` and runs the MM:SS BCD countdown shown during play (`num3_w..num0_w`). It produces the GAME_OVER linger timeout (`go_back_to_idle`) and the IDLE seconds counter (`game_over_seconds_w`). It observes `game_state_w` and sequences each counter per state.

## Interface
- `TICKS_PER_SEC`, default 1000: `game_clk` cycles per game second; must be ≥ 2.
- `START_TIME`, default 16'h0130: countdown preload as BCD `{num3,num2,num1,num0}` = MM:SS. It must be valid BCD and `num1` must be ≤ 5.
- `LINGER_SEC`, default 3: seconds held in GAME_OVER before `go_back_to_idle`; range 1..15.
- `game_clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `game_state_w`, in, 2: FSM state. IDLE=00, OPENING_SCREEN=01, GAME_RUNNING=10, GAME_OVER=11.
- `num0_w`, out, 4: seconds units (BCD).
- `num1_w`, out, 4: seconds tens (0..5).
- `num2_w`, out, 4: minutes units.
- `num3_w`, out, 4: minutes tens.
- `go_back_to_idle`, out, 1: level; GAME_OVER linger expired.
- `game_over_seconds_w`, out, 4: whole seconds spent in IDLE; saturates at 15.

## Operation
- **Registers:** prescaler `presc`; previous state `prev_state`; BCD digits; linger counter `linger` (4 b); `game_over_seconds`; `go_back_to_idle`. All outputs are registered.
- **State-entry detection:** `entry = (game_state_w != prev_state)`. `prev_state` follows `game_state_w` every cycle.
- **Prescaler:**
  - When `entry` is set or in OPENING_SCREEN, `presc` ← 0.
  - Otherwise, if `presc == TICKS_PER_SEC-1`, `presc` ← 0 and the internal `sec_tick` is set for that cycle.
  - Otherwise `presc` increments.
- **OPENING_SCREEN:**
  - Digits ← `START_TIME`.
  - `linger`, `game_over_seconds` and `go_back_to_idle` ← 0.
- **GAME_RUNNING:** on `sec_tick`, MM:SS decrements by 1 s with BCD borrow:
  - `num0`: 0→9, borrowing from `num1`.
  - `num1`: 0→5, borrowing from `num2`.
  - `num2`: 0→9, borrowing from `num3`.
  - At 00:00 the digits hold; no wrap to 99:59. The FSM detects the zero.
- **GAME_OVER:**
  - Digits are frozen.
  - On `entry`, `linger` ← 0 and `go_back_to_idle` ← 0.
  - On `sec_tick`, `linger` increments, saturating at 15.
  - `go_back_to_idle` ← 1 on the edge where `linger` becomes `LINGER_SEC`, and stays 1 while in GAME_OVER.
- **IDLE:**
  - On `entry`, `game_over_seconds` ← 0 and `go_back_to_idle` ← 0.
  - On `sec_tick`, `game_over_seconds` increments, saturating at 15. It therefore holds each value, including 8, for `TICKS_PER_SEC` cycles.
  - Digits are frozen.
- **Simultaneous events:** `entry` has priority over `sec_tick`, so no tick is counted on a state-entry cycle.

## Timing
- **Reset (async, `rst`=0):**
  - Digits = `START_TIME`.
  - `go_back_to_idle` = 0, `game_over_seconds_w` = 0, `presc` = 0, `linger` = 0.
  - `prev_state` = OPENING_SCREEN, matching the FSM reset state.
  - Assertion mid-operation takes effect immediately, without a clock edge.
- **Per-second period:** the first `sec_tick` in a state occurs `TICKS_PER_SEC+1` rising edges after the edge on which `game_state_w` entered that state. Subsequent ticks follow every `TICKS_PER_SEC` cycles.
- **Latency:** digit and counter updates are visible on the edge that completes the prescaler period; there is no extra output stage.
- **Countdown duration:** from 01:30, 00:00 is reached 90 ticks after entering GAME_RUNNING.
- **Linger duration:** `go_back_to_idle` rises `LINGER_SEC` ticks after GAME_OVER entry.
- **Unexpected state changes:** a jump back to OPENING_SCREEN (FSM reset or otherwise) reloads the digits on the next edge.

## Structure
- **Shared package `game_pkg`:** state encodings (`IDLE`, `OPENING_SCREEN`, `GAME_RUNNING`, `GAME_OVER`, 2 b) and a BCD digit typedef (4 b). `game_logic` and this block both import it.
- **Sub-module `sec_prescaler`:**
  - Parameter `TICKS_PER_SEC`.
  - Inputs: `game_clk`, `rst`, `clear`.
  - Output: `sec_tick`.
  - Counter width `$clog2(TICKS_PER_SEC)`.
- **Top level:** BCD MM:SS decrement logic, linger counter and IDLE counter.

## Test plan
All scenarios use `TICKS_PER_SEC`=4, `START_TIME`=16'h0130, `LINGER_SEC`=3.
- **Reset:** hold `rst`=0 → `num3..num0` = 0,1,3,0; `go_back_to_idle`=0; `game_over_seconds_w`=0.
- **First tick and minute borrow:** state 10 → digits 01:29 after 5 edges; 01:00→00:59 on the 31st tick.
- **Hold at zero:** state 10 held for 93 ticks → digits reach 00:00 at tick 90 and stay 0000 through ticks 91–93.
- **Linger:** state 11 after 10 s of play → digits frozen at 01:20; `go_back_to_idle` rises on edge 13 after entry and stays high.
- **IDLE count and saturation:** state 00 → `game_over_seconds_w` steps 0..8, each value held 4 cycles. Held in IDLE, it saturates at 15.
- **Reset mid-run and reload:** drop `rst` mid-GAME_RUNNING at 01:17 → digits read 01:30 asynchronously. State 01 after any state → digits reload to 01:30 on the next edge.
